// File: rtl/cpu_pkg.sv
// Shared types for the CPU bus arbiter: FSM states, grant encoding and
// wait-counter sizing.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int unsigned WAIT_MIN_W = 10;

  // Wait counter must hold TIMEOUT_CYCLES and be at least 10 bits wide.
  function automatic int unsigned wait_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w > WAIT_MIN_W) ? w : WAIT_MIN_W;
  endfunction

endpackage

// File: rtl/cpu_arb_slot.sv
// One-entry pending slot for one CPU port. The o_* view bypasses the
// incoming request so it can be granted on the same edge it is captured.
module cpu_arb_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_request,
  input  logic        i_open,
  input  logic        i_clear,
  input  logic [31:0] i_addr,
  input  logic        i_write,
  input  logic [3:0]  i_byte_enable,
  input  logic [31:0] i_wdata,
  output logic        o_pending,
  output logic [31:0] o_addr,
  output logic        o_write,
  output logic [3:0]  o_byte_enable,
  output logic [31:0] o_wdata
);

  logic        r_valid;
  logic [31:0] r_addr;
  logic        r_write;
  logic [3:0]  r_byte_enable;
  logic [31:0] r_wdata;
  logic        w_accept;

  // Requests into a full slot or while the port owns the bus are dropped.
  assign w_accept      = i_request & i_open & ~r_valid;
  assign o_pending     = r_valid | w_accept;
  assign o_addr        = r_valid ? r_addr        : i_addr;
  assign o_write       = r_valid ? r_write       : i_write;
  assign o_byte_enable = r_valid ? r_byte_enable : i_byte_enable;
  assign o_wdata       = r_valid ? r_wdata       : i_wdata;

  // Slot storage: capture on accept, empty when the arbiter grants it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_addr        <= '0;
      r_write       <= 1'b0;
      r_byte_enable <= '0;
      r_wdata       <= '0;
    end else begin
      r_valid <= o_pending & ~i_clear;
      if (w_accept) begin
        r_addr        <= i_addr;
        r_write       <= i_write;
        r_byte_enable <= i_byte_enable;
        r_wdata       <= i_wdata;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter between instruction-fetch and data ports onto a single
// shared memory bus, one transaction outstanding, with a wait timeout.
module cpu_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpui_request,
  input  logic [31:0] cpui_addr,
  output logic [31:0] cpui_rdata,
  output logic        cpui_ack,
  input  logic        cpud_request,
  input  logic [31:0] cpud_addr,
  input  logic        cpud_write,
  input  logic [3:0]  cpud_byte_enable,
  input  logic [31:0] cpud_wdata,
  output logic [31:0] cpud_rdata,
  output logic        cpud_ack,
  output logic        mem_request,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);

  localparam int unsigned      WAIT_W      = wait_width(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT_CYCLES);

  arb_state_t        r_state, w_state_next;
  grant_t            r_last_grant, w_grant;
  logic              w_grant_valid;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_request, r_mem_write;
  logic [31:0]       r_mem_addr, r_mem_wdata;
  logic [3:0]        r_mem_byte_enable;
  logic              w_busy, w_timeout, w_complete;
  logic              w_i_pending, w_i_write, w_d_pending, w_d_write;
  logic [31:0]       w_i_addr, w_i_wdata, w_d_addr, w_d_wdata;
  logic [3:0]        w_i_be, w_d_be;

  assign w_busy     = (r_state != IDLE);
  assign w_timeout  = w_busy & ~mem_ack & (r_wait == TIMEOUT_VAL);
  assign w_complete = w_busy & (mem_ack | w_timeout);

  cpu_arb_slot u_slot_i (
    .clock(clock), .reset(reset),
    .i_request(cpui_request), .i_open((r_state != BUSY_I) | w_complete),
    .i_clear(w_grant_valid & (w_grant == GRANT_I)),
    .i_addr(cpui_addr), .i_write(1'b0), .i_byte_enable(4'hF), .i_wdata('0),
    .o_pending(w_i_pending), .o_addr(w_i_addr), .o_write(w_i_write),
    .o_byte_enable(w_i_be), .o_wdata(w_i_wdata)
  );

  cpu_arb_slot u_slot_d (
    .clock(clock), .reset(reset),
    .i_request(cpud_request), .i_open((r_state != BUSY_D) | w_complete),
    .i_clear(w_grant_valid & (w_grant == GRANT_D)),
    .i_addr(cpud_addr), .i_write(cpud_write), .i_byte_enable(cpud_byte_enable),
    .i_wdata(cpud_wdata),
    .o_pending(w_d_pending), .o_addr(w_d_addr), .o_write(w_d_write),
    .o_byte_enable(w_d_be), .o_wdata(w_d_wdata)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and grant. Arbitration also runs on the completion edge so a
  // pending port issues in the cycle right after the ack, skipping IDLE.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = r_last_grant;
    w_state_next  = r_state;
    if (w_complete) w_state_next = IDLE;
    if ((r_state == IDLE) || w_complete) begin
      if (w_i_pending && w_d_pending) begin
        w_grant_valid = 1'b1;
        w_grant       = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
      end else if (w_d_pending) begin
        w_grant_valid = 1'b1;
        w_grant       = GRANT_D;
      end else if (w_i_pending) begin
        w_grant_valid = 1'b1;
        w_grant       = GRANT_I;
      end
    end
    if (w_grant_valid) w_state_next = (w_grant == GRANT_D) ? BUSY_D : BUSY_I;
  end

  // Issue registers, round-robin history and wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_request     <= 1'b0;
      r_mem_addr        <= '0;
      r_mem_write       <= 1'b0;
      r_mem_byte_enable <= '0;
      r_mem_wdata       <= '0;
      r_last_grant      <= GRANT_I;
      r_wait            <= '0;
    end else begin
      r_mem_request <= w_grant_valid;
      if (w_grant_valid) begin
        r_last_grant      <= w_grant;
        r_wait            <= '0;
        r_mem_addr        <= (w_grant == GRANT_D) ? w_d_addr  : w_i_addr;
        r_mem_write       <= (w_grant == GRANT_D) ? w_d_write : w_i_write;
        r_mem_byte_enable <= (w_grant == GRANT_D) ? w_d_be    : w_i_be;
        r_mem_wdata       <= (w_grant == GRANT_D) ? w_d_wdata : w_i_wdata;
      end else if (w_busy && !w_complete) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign mem_request     = r_mem_request;
  assign mem_addr        = r_mem_addr;
  assign mem_write       = r_mem_write;
  assign mem_byte_enable = r_mem_byte_enable;
  assign mem_wdata       = r_mem_wdata;

  // Completion routing to the owning port; suppressed while reset is asserted.
  always_comb begin
    cpui_ack   = 1'b0;
    cpui_rdata = '0;
    cpud_ack   = 1'b0;
    cpud_rdata = '0;
    bus_error  = 1'b0;
    if (!reset) begin
      bus_error = w_timeout;
      if (r_state == BUSY_I) begin
        cpui_ack = w_complete;
        if (mem_ack) cpui_rdata = mem_rdata;
      end
      if (r_state == BUSY_D) begin
        cpud_ack = w_complete;
        if (mem_ack) cpud_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: cycle table plus fairness and timeout
// sequences.
module tb_cpu_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpui_request, cpud_request, cpud_write, mem_ack;
  logic [31:0] cpui_addr, cpud_addr, cpud_wdata, mem_rdata;
  logic [3:0]  cpud_byte_enable;
  logic [31:0] cpui_rdata, cpud_rdata, mem_addr, mem_wdata;
  logic        cpui_ack, cpud_ack, mem_request, mem_write, bus_error;
  logic [3:0]  mem_byte_enable;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .cpui_request(cpui_request), .cpui_addr(cpui_addr),
    .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
    .cpud_request(cpud_request), .cpud_addr(cpud_addr),
    .cpud_write(cpud_write), .cpud_byte_enable(cpud_byte_enable),
    .cpud_wdata(cpud_wdata), .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  typedef struct {
    logic rst; logic ir; logic [31:0] ia;
    logic dr; logic [31:0] da; logic dw; logic [3:0] dbe; logic [31:0] dwd;
    logic mack; logic [31:0] mrd;
    logic e_mreq; logic [31:0] e_maddr; logic e_mwr; logic [3:0] e_mbe; logic [31:0] e_mwd;
    logic e_iack; logic [31:0] e_ird; logic e_dack; logic [31:0] e_drd; logic e_berr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic [31:0] da, input logic dw,
                     input logic [3:0] dbe, input logic [31:0] dwd,
                     input logic mack, input logic [31:0] mrd,
                     input logic emreq, input logic [31:0] emaddr, input logic emwr,
                     input logic [3:0] embe, input logic [31:0] emwd,
                     input logic eiack, input logic [31:0] eird,
                     input logic edack, input logic [31:0] edrd, input logic eberr);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dw = dw;
    v.dbe = dbe; v.dwd = dwd; v.mack = mack; v.mrd = mrd;
    v.e_mreq = emreq; v.e_maddr = emaddr; v.e_mwr = emwr; v.e_mbe = embe;
    v.e_mwd = emwd; v.e_iack = eiack; v.e_ird = eird; v.e_dack = edack;
    v.e_drd = edrd; v.e_berr = eberr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    cpui_request = 1'b0; cpui_addr = '0;
    cpud_request = 1'b0; cpud_addr = '0; cpud_write = 1'b0;
    cpud_byte_enable = '0; cpud_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned early;
    bit          exp_d;
    int          n;

    // rst ir ia        dr da         dw be    wdata         mack mrd            | mreq addr       wr be    wdata         iack irdata        dack drdata        berr
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            1, 32'h12345678,   0, 0,           0, 4'h0, 0,            0, 0,            0, 0,            0); // reset state, ack in IDLE ignored
    add(0, 0, 0,        1, 32'h100,   0, 4'hF, 0,            0, 0,              0, 0,           0, 4'h0, 0,            0, 0,            0, 0,            0); // single read request
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              1, 32'h100,     0, 4'hF, 0,            0, 0,            0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              0, 32'h100,     0, 4'hF, 0,            0, 0,            0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              0, 32'h100,     0, 4'hF, 0,            0, 0,            0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            1, 32'hDEADBEEF,   0, 32'h100,     0, 4'hF, 0,            0, 0,            1, 32'hDEADBEEF, 0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              0, 32'h100,     0, 4'hF, 0,            0, 0,            0, 0,            0);
    add(1, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              0, 32'h100,     0, 4'hF, 0,            0, 0,            0, 0,            0); // reset
    add(0, 1, 0,        1, 32'h200,   1, 4'h3, 32'hCAFEF00D, 0, 0,              0, 0,           0, 4'h0, 0,            0, 0,            0, 0,            0); // simultaneous
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              1, 32'h200,     1, 4'h3, 32'hCAFEF00D, 0, 0,            0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            1, 32'h11111111,   0, 32'h200,     1, 4'h3, 32'hCAFEF00D, 0, 0,            1, 32'h11111111, 0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              1, 0,           0, 4'hF, 0,            0, 0,            0, 0,            0);
    add(0, 0, 0,        1, 32'h300,   0, 4'hF, 0,            1, 32'h22222222,   0, 0,           0, 4'hF, 0,            1, 32'h22222222, 0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              1, 32'h300,     0, 4'hF, 0,            0, 0,            0, 0,            0);
    add(0, 0, 0,        1, 32'h304,   1, 4'hC, 32'hA5A5A5A5, 1, 32'h33333333,   0, 32'h300,     0, 4'hF, 0,            0, 0,            1, 32'h33333333, 0); // back-to-back
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              1, 32'h304,     1, 4'hC, 32'hA5A5A5A5, 0, 0,            0, 0,            0);
    add(0, 0, 0,        1, 32'h999,   0, 4'hF, 0,            0, 0,              0, 32'h304,     1, 4'hC, 32'hA5A5A5A5, 0, 0,            0, 0,            0); // violation ignored
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            1, 32'h44444444,   0, 32'h304,     1, 4'hC, 32'hA5A5A5A5, 0, 0,            1, 32'h44444444, 0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              0, 32'h304,     1, 4'hC, 32'hA5A5A5A5, 0, 0,            0, 0,            0);
    add(0, 0, 0,        1, 32'h400,   0, 4'hF, 0,            0, 0,              0, 32'h304,     1, 4'hC, 32'hA5A5A5A5, 0, 0,            0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              1, 32'h400,     0, 4'hF, 0,            0, 0,            0, 0,            0);
    add(1, 0, 0,        0, 0,         0, 4'h0, 0,            1, 32'h55555555,   0, 32'h400,     0, 4'hF, 0,            0, 0,            0, 0,            0); // reset in BUSY_D
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              0, 0,           0, 4'h0, 0,            0, 0,            0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            1, 32'h66666666,   0, 0,           0, 4'h0, 0,            0, 0,            0, 0,            0); // stray ack
    add(0, 0, 0,        1, 32'h500,   0, 4'hF, 0,            0, 0,              0, 0,           0, 4'h0, 0,            0, 0,            0, 0,            0);
    add(0, 1, 32'h40,   0, 0,         0, 4'h0, 0,            0, 0,              1, 32'h500,     0, 4'hF, 0,            0, 0,            0, 0,            0); // fetch waits in slot
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            1, 32'h77777777,   0, 32'h500,     0, 4'hF, 0,            0, 0,            1, 32'h77777777, 0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              1, 32'h40,      0, 4'hF, 0,            0, 0,            0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            1, 32'h88888888,   0, 32'h40,      0, 4'hF, 0,            1, 32'h88888888, 0, 0,            0);
    add(0, 0, 0,        0, 0,         0, 4'h0, 0,            0, 0,              0, 32'h40,      0, 4'hF, 0,            0, 0,            0, 0,            0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      cpui_request = vecs[i].ir; cpui_addr = vecs[i].ia;
      cpud_request = vecs[i].dr; cpud_addr = vecs[i].da; cpud_write = vecs[i].dw;
      cpud_byte_enable = vecs[i].dbe; cpud_wdata = vecs[i].dwd;
      mem_ack = vecs[i].mack; mem_rdata = vecs[i].mrd;
      @(negedge clock);
      chk("mem_request", i, mem_request, vecs[i].e_mreq);
      chk("mem_addr", i, mem_addr, vecs[i].e_maddr);
      chk("mem_write", i, mem_write, vecs[i].e_mwr);
      chk("mem_byte_enable", i, mem_byte_enable, vecs[i].e_mbe);
      chk("mem_wdata", i, mem_wdata, vecs[i].e_mwd);
      chk("cpui_ack", i, cpui_ack, vecs[i].e_iack);
      chk("cpui_rdata", i, cpui_rdata, vecs[i].e_ird);
      chk("cpud_ack", i, cpud_ack, vecs[i].e_dack);
      chk("cpud_rdata", i, cpud_rdata, vecs[i].e_drd);
      chk("bus_error", i, bus_error, vecs[i].e_berr);
      tick();
    end

    // Fairness: the acked port re-requests in its ack cycle; grants alternate D,I,...
    do_reset();
    cpui_request = 1'b1; cpui_addr = 32'h1000;
    cpud_request = 1'b1; cpud_addr = 32'h2000;
    tick();
    drive_idle();
    for (int k = 0; k < 8; k++) begin
      exp_d = (k % 2 == 0);
      n = 0;
      @(negedge clock);
      while (mem_request !== 1'b1 && n < 6) begin
        @(negedge clock);
        n++;
      end
      chk("fair_issue", k, mem_request, 1);
      chk("fair_port", k, mem_addr[15:12], exp_d ? 2 : 1);
      @(posedge clock);
      #1;
      mem_ack = 1'b1; mem_rdata = 32'h100 + k;
      if (exp_d) begin
        cpud_request = 1'b1; cpud_addr = 32'h2000 + k;
      end else begin
        cpui_request = 1'b1; cpui_addr = 32'h1000 + k;
      end
      @(negedge clock);
      chk("fair_ack_d", k, cpud_ack, exp_d);
      chk("fair_ack_i", k, cpui_ack, !exp_d);
      chk("fair_rdata", k, exp_d ? cpud_rdata : cpui_rdata, 32'h100 + k);
      tick();
      drive_idle();
    end

    // Timeout with TIMEOUT_CYCLES=16: forced ack 16 cycles after issue, late ack ignored.
    do_reset();
    cpud_request = 1'b1; cpud_addr = 32'h600; cpud_byte_enable = 4'hF;
    mem_rdata = 32'hBAD0BAD0;
    tick();
    cpud_request = 1'b0;
    early = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      if (j == 0) chk("to_issue", j, mem_request, 1);
      if (cpud_ack !== 1'b0 || cpui_ack !== 1'b0 || bus_error !== 1'b0) early++;
      tick();
    end
    chk("to_no_early_ack", 0, early, 0);
    @(negedge clock);
    chk("to_cpud_ack", 16, cpud_ack, 1);
    chk("to_cpud_rdata", 16, cpud_rdata, 0);
    chk("to_bus_error", 16, bus_error, 1);
    chk("to_cpui_ack", 16, cpui_ack, 0);
    tick();
    mem_ack = 1'b1;
    @(negedge clock);
    chk("late_cpud_ack", 17, cpud_ack, 0);
    chk("late_cpud_rdata", 17, cpud_rdata, 0);
    chk("late_bus_error", 17, bus_error, 0);
    chk("late_mem_request", 17, mem_request, 0);
    tick();
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
